// File: rtl/glyph_row_fetch_pkg.sv
// Shared constants and helpers for the glyph row fetch block.
// Width helper guards against $clog2(1) == 0 on degenerate geometries.
package glyph_row_fetch_pkg;

    localparam int FONT_CODE_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glyph_tag_pipe.sv
// Delay line carrying {valid, col} alongside the text-read/glyph-lookup latency.
// Only the valid bits are reset; column tags are don't-care when invalid.
module glyph_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [CW-1:0] push_col,
    output logic          out_vld,
    output logic [CW-1:0] out_col,
    output logic          empty
);

    logic [DEPTH-1:0] vld;
    logic [CW-1:0]    col_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[DEPTH-2:0], push};
        end
    end

    always_ff @(posedge clk) begin
        col_p[0] <= push_col;
        for (int i = 1; i < DEPTH; i++) begin
            col_p[i] <= col_p[i-1];
        end
    end

    assign out_vld = vld[DEPTH-1];
    assign out_col = col_p[DEPTH-1];
    assign empty   = ~|vld;

endmodule

// File: rtl/glyph_row_fetch.sv
// Fetches one pixel line of one text row: text buffer -> glyph lookup -> line buffer,
// one character per clock, with a tag pipeline matching the two lookup latencies.
module glyph_row_fetch
    import glyph_row_fetch_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 16,
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int TXT_LAT   = 1,
    parameter int GLYPH_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(ROWS)-1:0]      row,
    input  logic [$clog2(HEIGHT)-1:0]    line_id,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(COLS*ROWS)-1:0] txt_addr,
    input  logic [FONT_CODE_W-1:0]       txt_data,
    output logic [FONT_CODE_W-1:0]       g_ucp,
    output logic [$clog2(HEIGHT)-1:0]    g_line_id,
    input  logic [WIDTH-1:0]             g_glyph_line,
    output logic                         lb_we,
    output logic [$clog2(COLS)-1:0]      lb_addr,
    output logic [WIDTH-1:0]             lb_data
);

    localparam int AW    = idx_w(COLS * ROWS);
    localparam int CW    = idx_w(COLS);
    localparam int RW    = idx_w(ROWS);
    // Stage 0 lines up with the registered txt_addr; the rest covers both lookup latencies.
    localparam int DEPTH = TXT_LAT + GLYPH_LAT + 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row_q;
    logic          push;
    logic          tag_vld;
    logic [CW-1:0] tag_col;
    logic          tag_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (col == LAST_COL) state_nxt = DRAIN;
            DRAIN:   if (tag_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ISSUE) || (state == DRAIN);
        done = (state == DONE);
        push = (state == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row_q     <= '0;
            g_line_id <= '0;
            txt_addr  <= '0;
        end else begin
            if (state == IDLE && start) begin
                col       <= '0;
                row_q     <= row;
                g_line_id <= line_id;
            end else if (push) begin
                col <= col + 1'b1;
            end
            if (push) begin
                txt_addr <= AW'(row_q) * AW'(COLS) + AW'(col);
            end
        end
    end

    // The glyph lookup registers its own inputs, so the code point passes straight through.
    assign g_ucp = txt_data;

    glyph_tag_pipe #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_col (col),
        .out_vld  (tag_vld),
        .out_col  (tag_col),
        .empty    (tag_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_we   <= 1'b0;
            lb_addr <= '0;
            lb_data <= '0;
        end else begin
            lb_we <= tag_vld;
            if (tag_vld) begin
                lb_addr <= tag_col;
                lb_data <= g_glyph_line;
            end
        end
    end

endmodule

// File: tb/tb_glyph_row_fetch.sv
// Directed bench for glyph_row_fetch: default geometry plus a small COLS=4 variant,
// with behavioural text RAM and glyph lookup models.
module tb_glyph_row_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = -1000;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] mem_val(input int a);
        return 8'(8'h41 + a);
    endfunction

    function automatic logic [7:0] exp_line(input int a, input logic [3:0] lid);
        logic [7:0] m;
        m = mem_val(a);
        return {m[3:0], lid};
    endfunction

    // ---------------- main instance (defaults) ----------------
    logic        start = 1'b0;
    logic [4:0]  row = '0;
    logic [3:0]  line_id = '0;
    logic        busy, done, lb_we;
    logic [11:0] txt_addr;
    logic [7:0]  txt_data = '0, g_ucp, g_glyph_line = '0, lb_data;
    logic [3:0]  g_line_id;
    logic [6:0]  lb_addr;
    logic [7:0]  g_p0 = '0, g_p1 = '0;

    glyph_row_fetch dut (
        .clk(clk), .rst(rst), .start(start), .row(row), .line_id(line_id),
        .busy(busy), .done(done), .txt_addr(txt_addr), .txt_data(txt_data),
        .g_ucp(g_ucp), .g_line_id(g_line_id), .g_glyph_line(g_glyph_line),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
    );

    always @(posedge clk) begin
        txt_data     <= mem_val(int'(txt_addr));
        g_p0         <= {g_ucp[3:0], g_line_id};
        g_p1         <= g_p0;
        g_glyph_line <= g_p1;
    end

    int n_wr, first_wr, last_wr, n_done, done_cyc, bad_cont, bad_order, bad_data;
    int both_hi, lid_bad, addr_first, addr_last;
    logic [7:0] first_data;
    int row_tb;
    logic [3:0] lid_tb;

    always @(negedge clk) begin
        if (!rst) begin
            if (lb_we) begin
                if (n_wr == 0) begin
                    first_wr   = cyc - t0;
                    first_data = lb_data;
                end else if (cyc - t0 != last_wr + 1) begin
                    bad_cont++;
                end
                if (int'(lb_addr) != n_wr) bad_order++;
                if (lb_data != exp_line(row_tb * 80 + int'(lb_addr), lid_tb)) bad_data++;
                last_wr = cyc - t0;
                n_wr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc - t0;
            end
            if (busy && done) both_hi++;
            if (busy && g_line_id != lid_tb) lid_bad++;
            if (cyc - t0 == 1)  addr_first = int'(txt_addr);
            if (cyc - t0 == 80) addr_last  = int'(txt_addr);
        end
    end

    // ---------------- small instance (COLS=4, TXT_LAT=2, GLYPH_LAT=1) ----------------
    logic       s_start = 1'b0;
    logic       s_row = 1'b0;
    logic [3:0] s_lid = '0;
    logic       s_busy, s_done, s_we;
    logic [2:0] s_txt_addr;
    logic [7:0] s_txt_data = '0, s_t1 = '0, s_ucp, s_glyph = '0, s_lb_data;
    logic [3:0] s_gl;
    logic [1:0] s_lb_addr;

    glyph_row_fetch #(.WIDTH(8), .HEIGHT(16), .COLS(4), .ROWS(2), .TXT_LAT(2), .GLYPH_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .row(s_row), .line_id(s_lid),
        .busy(s_busy), .done(s_done), .txt_addr(s_txt_addr), .txt_data(s_txt_data),
        .g_ucp(s_ucp), .g_line_id(s_gl), .g_glyph_line(s_glyph),
        .lb_we(s_we), .lb_addr(s_lb_addr), .lb_data(s_lb_data)
    );

    always @(posedge clk) begin
        s_t1       <= mem_val(int'(s_txt_addr));
        s_txt_data <= s_t1;
        s_glyph    <= {s_ucp[3:0], s_gl};
    end

    int s_n_wr, s_first, s_last, s_n_done, s_done_cyc, s_bad;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_we) begin
                if (s_n_wr == 0) s_first = cyc - t0;
                s_last = cyc - t0;
                if (int'(s_lb_addr) != s_n_wr) s_bad++;
                if (s_lb_data != exp_line(4 + int'(s_lb_addr), 4'd9)) s_bad++;
                s_n_wr++;
            end
            if (s_done) begin
                s_n_done++;
                s_done_cyc = cyc - t0;
            end
            if (s_busy && s_done) s_bad++;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_mon();
        n_wr = 0; first_wr = -1; last_wr = -1; n_done = 0; done_cyc = -1;
        bad_cont = 0; bad_order = 0; bad_data = 0; both_hi = 0; lid_bad = 0;
        addr_first = -1; addr_last = -1; first_data = '0;
        s_n_wr = 0; s_first = -1; s_last = -1; s_n_done = 0; s_done_cyc = -1; s_bad = 0;
    endtask

    // Leaves the bench 1ns into cycle 0 (the cycle after the accepting edge).
    task automatic launch(input int r, input logic [3:0] l);
        clear_mon();
        row_tb = r; lid_tb = l;
        row = 5'(r); line_id = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; t0 = cyc;
    endtask

    task automatic to_cycle(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_run(input string tag, input int r);
        n_checks++; if (n_wr !== 80) begin n_fail++; $display("FAIL %s writes: got %0d want 80", tag, n_wr); end
        n_checks++; if (first_wr !== 6) begin n_fail++; $display("FAIL %s first_wr_cycle: got %0d want 6", tag, first_wr); end
        n_checks++; if (last_wr !== 85) begin n_fail++; $display("FAIL %s last_wr_cycle: got %0d want 85", tag, last_wr); end
        n_checks++; if (bad_cont + bad_order !== 0) begin n_fail++; $display("FAIL %s order: got %0d gaps/misorders want 0", tag, bad_cont + bad_order); end
        n_checks++; if (bad_data !== 0) begin n_fail++; $display("FAIL %s data: got %0d bad words want 0", tag, bad_data); end
        n_checks++; if (n_done !== 1 || done_cyc !== 86) begin n_fail++; $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at 86", tag, n_done, done_cyc); end
        n_checks++; if (both_hi !== 0 || lid_bad !== 0) begin n_fail++; $display("FAIL %s busy_done/g_line_id: got %0d/%0d want 0/0", tag, both_hi, lid_bad); end
        n_checks++; if (addr_first !== r * 80 || addr_last !== r * 80 + 79) begin n_fail++; $display("FAIL %s txt_addr: got %0d..%0d want %0d..%0d", tag, addr_first, addr_last, r * 80, r * 80 + 79); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || lb_we !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b we=%b want 0 0 0", busy, done, lb_we); end
        n_checks++; if (txt_addr !== 12'd0 || lb_addr !== 7'd0 || lb_data !== 8'd0 || g_line_id !== 4'd0) begin n_fail++; $display("FAIL reset_data: got addr=%0d lba=%0d lbd=%h gl=%0d want 0", txt_addr, lb_addr, lb_data, g_line_id); end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        launch(0, 4'd5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        to_cycle(95);
        check_run("single", 0);
        n_checks++; if (first_data !== 8'h15) begin n_fail++; $display("FAIL single_word0: got %h want 15", first_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_last_row();
        launch(29, 4'd7);
        to_cycle(95);
        check_run("last_row", 29);
    endtask

    task automatic test_start_busy();
        launch(0, 4'd3);
        to_cycle(10);
        start = 1'b1; row = 5'd5; line_id = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        to_cycle(86);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: got busy=%b at cycle 87 want 0", busy); end
        to_cycle(100);
        check_run("start_busy", 0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_late: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        launch(1, 4'd2);
        to_cycle(87);
        n_checks++; if (n_wr !== 80 || n_done !== 1) begin n_fail++; $display("FAIL b2b_first: got %0d writes %0d done want 80 1", n_wr, n_done); end
        launch(2, 4'd15);
        n_checks++; if (g_line_id !== 4'd15 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got gl=%0d busy=%b want 15 1", g_line_id, busy); end
        to_cycle(95);
        check_run("b2b_second", 2);
    endtask

    task automatic test_reset_mid();
        launch(0, 4'd5);
        to_cycle(40);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || lb_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_now: got busy=%b we=%b done=%b want 0 0 0", busy, lb_we, done); end
        n_checks++; if (n_wr !== 34) begin n_fail++; $display("FAIL mid_reset_count: got %0d writes want 34", n_wr); end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_checks++; if (n_wr !== 34 || n_done !== 0) begin n_fail++; $display("FAIL mid_reset_after: got %0d writes %0d done want 34 0", n_wr, n_done); end
        test_single();
    endtask

    task automatic test_small();
        clear_mon();
        s_row = 1'b1; s_lid = 4'd9; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; t0 = cyc;
        to_cycle(15);
        n_checks++; if (s_n_wr !== 4 || s_first !== 5 || s_last !== 8) begin n_fail++; $display("FAIL small_writes: got %0d in %0d..%0d want 4 in 5..8", s_n_wr, s_first, s_last); end
        n_checks++; if (s_n_done !== 1 || s_done_cyc !== 9) begin n_fail++; $display("FAIL small_done: got %0d at %0d want 1 at 9", s_n_done, s_done_cyc); end
        n_checks++; if (s_bad !== 0) begin n_fail++; $display("FAIL small_data: got %0d errors want 0", s_bad); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_last_row();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
